weight_load_ctrl: RTL and testbench
===================================

# weight_load_ctrl

Sequencer that fills the 4-entry weight register bank of one neuron from a byte stream. Accepts weights over a valid/ready handshake after a start command, writes them to bank addresses 0..NUM_WEIGHTS-1 in order with single-cycle write strobes, and reports completion. Sits between the host/config interface and the neuron's weight register bank, driving that bank's data, address and write inputs.

## Interface

**Parameters**
- DATA_W, 8, weight width; matches the bank data port.
- NUM_WEIGHTS, 4, number of bank entries loaded per sequence (≥2, ≤2^ADDR_W).
- ADDR_W, 2, bank address width.

**Ports**
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  in  1  begin a load sequence; honoured only in IDLE.
- abort  in  1  cancel an in-progress sequence; honoured only in LOAD.
- in_data  in  DATA_W  weight byte from upstream.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller can accept a weight this cycle.
- wb_data  out  DATA_W  data to bank (registered).
- wb_addr  out  ADDR_W  address to bank (registered).
- wb_write  out  1  bank write strobe, one cycle per weight (registered).
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse after the final weight is written.
- loaded  out  1  level; bank holds a complete set from the last sequence.

## Operation

- **States:** IDLE, LOAD, WRITE, DONE.
  - **IDLE:** in_ready=0, wb_write=0.
    - start=1 → LOAD, ptr←0, loaded←0.
    - start=0 → stay.
  - **LOAD:** in_ready=1.
    - abort=1 → IDLE; no write; loaded stays 0.
    - Otherwise in_valid=1 → capture wb_data←in_data and wb_addr←ptr, then go to WRITE.
    - Otherwise stay.
  - **WRITE:** wb_write=1 and in_ready=0 for exactly one cycle.
    - ptr==NUM_WEIGHTS-1 → DONE.
    - Otherwise ptr←ptr+1, then LOAD.
  - **DONE:** done=1 and loaded←1 for one cycle, then IDLE.
- **Internal pointer:** ptr is ADDR_W bits. It never wraps within a sequence and is reset to 0 on every start.
- **Output stability:** wb_data and wb_addr hold their last values outside WRITE. Only wb_write qualifies them.
- **Ignored inputs:**
  - start is ignored outside IDLE, and start held high is not re-armed until IDLE.
  - abort is ignored outside LOAD, so WRITE and DONE always complete.
- **Simultaneous events:**
  - abort and in_valid together in LOAD: abort wins and the byte is not consumed.
  - start and abort together in IDLE: start wins.
- **Reset (reset=0), at any time including mid-sequence:** state→IDLE, ptr→0. Every output reads 0: in_ready, wb_data, wb_addr, wb_write, busy, done and loaded. The bank keeps any partially written contents; loaded=0 flags them as invalid.

## Timing

- start sampled high at edge T → busy=1 and in_ready=1 from T+1.
- Handshake completes at edge E (in_valid & in_ready) → wb_write=1 with the matching wb_data/wb_addr during cycle E..E+1. The bank captures at edge E+1.
- in_ready returns high at E+1 (back in LOAD). Maximum throughput is one weight per 2 cycles.
- Final write cycle ends at edge F:
  - done=1 during F..F+1.
  - loaded=1 from F.
  - busy=0 from F+1.
- Best-case full load, from start edge to done: 2·NUM_WEIGHTS+1 cycles, which is 9 for the defaults.
- in_data and in_valid are only sampled when in_ready=1. Upstream holds in_data stable while in_valid=1 && in_ready=0.
- Reset deassertion is synchronised externally. The controller leaves IDLE no earlier than the first rising edge with reset=1 and start=1.

## Test plan

1. **Reset state:** Assert reset=0 mid-cycle. Required: all outputs 0 immediately. Then release, hold start=0 for 5 cycles. Required: state IDLE, busy=0.
2. **Back-to-back load:** Pulse start, then in_valid=1 constantly with data 0x11,0x22,0x33,0x44.
   - Four wb_write pulses at addr 0,1,2,3 with those data, spaced 2 cycles apart.
   - done pulse one cycle after the last write.
   - loaded=1, busy=0 next cycle.
3. **Stalled upstream:** Same as 2, but in_valid drops for 3 cycles before the third weight.
   - in_ready stays high and no wb_write during the gap.
   - addr 2 then written with 0x33. Total 4 writes.
4. **Abort:** After two weights are written, assert abort together with in_valid (data 0x55).
   - No write of 0x55, no done.
   - busy=0 next cycle, loaded=0.
   - A following start restarts at addr 0.
5. **Mid-sequence reset:** Assert reset=0 during a WRITE cycle.
   - wb_write drops immediately, loaded=0.
   - After release, a full sequence loads addr 0..3 correctly.
6. **Ignored start:** Pulse start during LOAD and WRITE. Required: no pointer reset, sequence completes normally with exactly 4 writes.

Source files
------------

// File: rtl/weight_load_ctrl.sv
// Weight-bank load sequencer: accepts NUM_WEIGHTS bytes over valid/ready
// after a start command and writes them to bank addresses 0..NUM_WEIGHTS-1.
module weight_load_ctrl #(
   parameter int DATA_W      = 8,
   parameter int NUM_WEIGHTS = 4,
   parameter int ADDR_W      = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [ADDR_W-1:0] wb_addr,
   output logic              wb_write,
   output logic              busy,
   output logic              done,
   output logic              loaded
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WEIGHTS - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] ptr;
   logic              last;

   assign last = (ptr == LAST);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD: begin
            if (abort)         state_nx = IDLE;
            else if (in_valid) state_nx = WRITE;
         end
         WRITE:   state_nx = last ? DONE : LOAD;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Status outputs are flopped from the next state so they change with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready <= 1'b0;
         wb_write <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         in_ready <= (state_nx == LOAD);
         wb_write <= (state_nx == WRITE);
         busy     <= (state_nx != IDLE);
         done     <= (state_nx == DONE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr     <= '0;
         wb_data <= '0;
         wb_addr <= '0;
         loaded  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ptr    <= '0;
                  loaded <= 1'b0;
               end
            end
            LOAD: begin
               if (!abort && in_valid) begin
                  wb_data <= in_data;
                  wb_addr <= ptr;
               end
            end
            WRITE: begin
               if (last) loaded <= 1'b1;
               else      ptr    <= ptr + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: behavioural model compared every
// cycle, plus directed sequences with literal expectations and a random phase.
module tb_weight_load_ctrl;
   localparam int DW = 8;
   localparam int NW = 4;
   localparam int AW = 2;

   logic          clk = 0, reset = 0, start = 0, abort = 0, in_valid = 0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, wb_write, busy, done, loaded;
   logic [DW-1:0] wb_data;
   logic [AW-1:0] wb_addr;

   weight_load_ctrl #(.DATA_W(DW), .NUM_WEIGHTS(NW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .wb_data(wb_data), .wb_addr(wb_addr), .wb_write(wb_write),
      .busy(busy), .done(done), .loaded(loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a sequence is "active" from start until the done pulse ends;
   // each accepted byte produces one write cycle, the NW-th write is followed by done.
   logic          m_active = 0, m_wr = 0, m_fin = 0, m_loaded = 0;
   int            m_cnt = 0;
   logic [DW-1:0] m_data = '0;
   logic [AW-1:0] m_addr = '0;
   logic          hs = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_active = 0; m_wr = 0; m_fin = 0; m_loaded = 0;
         m_cnt = 0; m_data = '0; m_addr = '0; hs = 0;
      end else if (m_fin) begin
         m_fin = 0; m_active = 0;
      end else if (m_wr) begin
         m_wr = 0;
         if (m_cnt == NW) begin m_fin = 1; m_loaded = 1; end
      end else if (m_active) begin
         if (abort) m_active = 0;
         else if (in_valid) begin
            hs = 1;
            m_wr = 1; m_data = in_data; m_addr = AW'(m_cnt); m_cnt++;
         end
      end else if (start) begin
         m_active = 1; m_cnt = 0; m_loaded = 0;
      end
   end

   int log_addr[$], log_data[$], log_cyc[$];
   int done_cnt = 0, done_cyc = 0;

   always @(negedge clk) begin
      chk("in_ready", in_ready, m_active && !m_wr && !m_fin);
      chk("busy",     busy,     m_active);
      chk("done",     done,     m_fin);
      chk("wb_write", wb_write, m_wr);
      chk("wb_data",  wb_data,  m_data);
      chk("wb_addr",  wb_addr,  m_addr);
      chk("loaded",   loaded,   m_loaded);
      if (wb_write === 1'b1) begin
         log_addr.push_back(int'(wb_addr)); log_data.push_back(int'(wb_data)); log_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
   end

   // Directed upstream source
   logic [DW-1:0] q[$];
   int sent = 0, gap_idx = -1, gap_left = 0;

   task automatic tick();
      @(negedge clk); #1;
      if (hs) begin hs = 0; q.delete(0); sent++; end
      if (q.size() > 0 && !(sent == gap_idx && gap_left > 0)) begin
         in_valid = 1; in_data = q[0];
      end else begin
         in_valid = 0;
         if (sent == gap_idx && gap_left > 0) gap_left--;
      end
   endtask

   task automatic clear_tb();
      q.delete(); log_addr.delete(); log_data.delete(); log_cyc.delete();
      sent = 0; gap_idx = -1; gap_left = 0; done_cnt = 0; hs = 0;
      in_valid = 0; start = 0; abort = 0;
   endtask

   task automatic pulse_start();
      start = 1; tick(); start = 0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      chk("done_seen", done_cnt != d0, 1);
   endtask

   task automatic check_log(input string tag, input int b0, input int b1, input int b2, input int b3);
      int exp_d[4];
      exp_d = '{b0, b1, b2, b3};
      chk({tag, "_nwrites"}, log_addr.size(), NW);
      for (int i = 0; i < NW && i < log_addr.size(); i++) begin
         chk({tag, "_addr"}, log_addr[i], i);
         chk({tag, "_data"}, log_data[i], exp_d[i]);
      end
   endtask

   initial begin
      int s;
      // 1: reset state and immediate async clear
      #12 reset = 1;
      clear_tb();
      tick(); pulse_start(); tick(); tick();
      @(posedge clk); #2 reset = 0; #1;
      chk("rst_now_out", {in_ready, wb_write, busy, done, loaded, wb_addr, wb_data}, 0);
      @(negedge clk); #1 reset = 1;
      repeat (5) begin tick(); chk("idle_busy", busy, 0); chk("idle_ready", in_ready, 0); end

      // 2: back-to-back load
      clear_tb();
      q = '{8'h11, 8'h22, 8'h33, 8'h44};
      tick(); pulse_start(); s = cyc;
      wait_done(40);
      check_log("b2b", 'h11, 'h22, 'h33, 'h44);
      for (int i = 0; i + 1 < log_cyc.size(); i++) chk("b2b_spacing", log_cyc[i+1] - log_cyc[i], 2);
      if (log_cyc.size() == NW) chk("b2b_done_after_last", done_cyc - log_cyc[NW-1], 1);
      // counted inclusive of the cycle in which start is sampled
      chk("b2b_start_to_done", done_cyc - s + 1, 2*NW + 1);
      tick(); chk("b2b_loaded", loaded, 1); chk("b2b_busy", busy, 0);

      // 3: stalled upstream before third weight
      clear_tb();
      q = '{8'h11, 8'h22, 8'h33, 8'h44}; gap_idx = 2; gap_left = 3;
      tick(); pulse_start();
      wait_done(60);
      check_log("stall", 'h11, 'h22, 'h33, 'h44);
      if (log_cyc.size() == NW) chk("stall_gap", log_cyc[2] - log_cyc[1], 4);

      // 4: abort with simultaneous in_valid
      tick(); clear_tb();
      q = '{8'h11, 8'h22, 8'h55};
      tick(); pulse_start();
      for (int i = 0; i < 20 && log_addr.size() < 2; i++) tick();
      chk("abort_two_written", log_addr.size(), 2);
      tick();
      abort = 1; tick(); abort = 0; q.delete(); in_valid = 0;
      chk("abort_busy", busy, 0); chk("abort_loaded", loaded, 0);
      repeat (5) tick();
      chk("abort_nwrites", log_addr.size(), 2); chk("abort_no_done", done_cnt, 0);
      clear_tb();
      q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      tick(); pulse_start();
      wait_done(40);
      check_log("restart", 'hA1, 'hA2, 'hA3, 'hA4);

      // 5: reset during WRITE
      tick(); clear_tb();
      q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      tick(); pulse_start();
      for (int i = 0; i < 20 && log_addr.size() < 2; i++) tick();
      chk("mid_in_write", wb_write, 1);
      #2 reset = 0; #1;
      chk("mid_rst_write", wb_write, 0); chk("mid_rst_loaded", loaded, 0);
      chk("mid_rst_busy", busy, 0); chk("mid_rst_addr", wb_addr, 0);
      @(negedge clk); #1 reset = 1;
      clear_tb();
      q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
      tick(); pulse_start();
      wait_done(40);
      check_log("after_rst", 'hD1, 'hD2, 'hD3, 'hD4);

      // 6: start asserted during LOAD/WRITE is ignored
      tick(); clear_tb();
      q = '{8'h61, 8'h62, 8'h63, 8'h64};
      tick(); pulse_start();
      start = 1; repeat (4) tick(); start = 0;
      wait_done(40);
      check_log("ign_start", 'h61, 'h62, 'h63, 'h64);
      tick();

      // random phase, checked by the per-cycle model comparison
      clear_tb();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         start = ($urandom % 6 == 0);
         abort = ($urandom % 12 == 0);
         if (!(in_valid && !in_ready)) begin
            in_valid = ($urandom % 3 != 0);
            in_data  = DW'($urandom);
         end
         if ($urandom % 400 == 0) begin #1 reset = 0; #1 reset = 1; end
      end
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
